mdu_ctrl: RTL

Multi-cycle multiply/divide sequencer for the EX stage of the 5-stage MIPS pipeline. Accepts MULT/MULTU/DIV/DIVU from EX and runs an iterative shift-add multiplier or restoring divider. Holds the pipeline via a stall request while busy. Is the single writer of the HI/LO register pair, merging MDU results with MTHI/MTLO writes.

---
 rtl/mdu_ctrl.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mdu_ctrl.sv
// ============================================================================
//  Module      : mdu_ctrl
//  Description : Multi-cycle multiply/divide sequencer for the EX stage.
//                Runs a 32-iteration shift-add multiplier or a restoring
//                divider on operand magnitudes, fixes up signs at the end,
//                requests an IF..EX stall while busy and is the only writer
//                of the HI/LO pair (MDU results merged with MTHI/MTLO).
//  Options     : MDU_FAST_MUL_EN - when defined, MULT/MULTU complete through
//                a single-cycle 32x32 product (IDLE -> DONE); divide is
//                always iterative.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  op,              // one-hot {mult, multu, div, divu}
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        annul,
    output logic        stallreq_for_ex,
    output logic        ready,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DZERO = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // ------------------------------------------------------------------
    // Optional single-cycle multiplier
    // ------------------------------------------------------------------
`ifdef MDU_FAST_MUL_EN
    localparam logic c_FAST_MUL = 1'b1;
    logic signed [63:0] w_sprod;
    logic        [63:0] w_uprod;
    logic        [63:0] w_fast_prod;
    assign w_sprod     = $signed(src1) * $signed(src2);
    assign w_uprod     = {32'd0, src1} * {32'd0, src2};
    assign w_fast_prod = op[3] ? w_sprod : w_uprod;
`else
    localparam logic c_FAST_MUL = 1'b0;
    logic [63:0] w_fast_prod;
    assign w_fast_prod = 64'd0;
`endif

    // ------------------------------------------------------------------
    // Operation decode (only meaningful while IDLE)
    // ------------------------------------------------------------------
    logic        w_op_any;
    logic        w_op_div;
    logic        w_op_signed;
    logic        w_accept;
    logic        w_div_zero;
    logic        w_fast_path;
    logic [31:0] w_abs1;
    logic [31:0] w_abs2;

    assign w_op_any    = |op;
    assign w_op_div    = op[1] | op[0];
    assign w_op_signed = op[3] | op[1];
    // A request presented while reset is asserted is never taken.
    assign w_accept    = (r_state == S_IDLE) && w_op_any && !annul && !rst;
    assign w_div_zero  = w_op_div && (src2 == 32'd0);
    assign w_fast_path = c_FAST_MUL && !w_op_div;
    assign w_abs1      = (w_op_signed && src1[31]) ? (32'd0 - src1) : src1;
    assign w_abs2      = (w_op_signed && src2[31]) ? (32'd0 - src2) : src2;

    // ------------------------------------------------------------------
    // Iterative datapath state
    //   r_rq   : multiply {partial product, multiplier shifting out}
    //            divide   {partial remainder, dividend/quotient}
    //   r_dvsr : multiplicand (mult) or divisor (div) magnitude
    // ------------------------------------------------------------------
    logic [63:0] r_rq;
    logic [31:0] r_dvsr;
    logic [4:0]  r_cnt;
    logic        r_is_div;
    logic        r_neg_res;   // negate product / quotient
    logic        r_neg_rem;   // remainder follows dividend sign

    // One shift-add step: add multiplicand into the upper half when the
    // current multiplier LSB is set, then shift the 65-bit result right.
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    assign w_mul_sum  = {1'b0, r_rq[63:32]} + (r_rq[0] ? {1'b0, r_dvsr} : 33'd0);
    assign w_mul_next = {w_mul_sum, r_rq[31:1]};

    // One restoring-division step. The partial remainder is always below
    // the divisor, so after the shift it is below twice the divisor and a
    // 33-bit subtract is enough: bit 32 of the difference is the borrow.
    logic [32:0] w_div_part;
    logic [32:0] w_div_diff;
    logic [63:0] w_div_next;
    assign w_div_part = r_rq[63:31];
    assign w_div_diff = w_div_part - {1'b0, r_dvsr};
    assign w_div_next = w_div_diff[32] ? {w_div_part[31:0], r_rq[30:0], 1'b0}
                                       : {w_div_diff[31:0], r_rq[30:0], 1'b1};

    logic [63:0] w_rq_next;
    assign w_rq_next = r_is_div ? w_div_next : w_mul_next;

    // Sign fix-up applied to the value produced by the final iteration.
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;
    logic [31:0] w_fin_hi;
    logic [31:0] w_fin_lo;
    assign w_prod_fix = r_neg_res ? (64'd0 - w_rq_next) : w_rq_next;
    assign w_quo_fix  = r_neg_res ? (32'd0 - w_rq_next[31:0])  : w_rq_next[31:0];
    assign w_rem_fix  = r_neg_rem ? (32'd0 - w_rq_next[63:32]) : w_rq_next[63:32];
    assign w_fin_hi   = r_is_div ? w_rem_fix : w_prod_fix[63:32];
    assign w_fin_lo   = r_is_div ? w_quo_fix : w_prod_fix[31:0];

    logic w_last_iter;
    assign w_last_iter = (r_state == S_BUSY) && (r_cnt == 5'd31) && !annul;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state decode and combinational stall request
    always_comb begin
        w_state_next    = r_state;
        stallreq_for_ex = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    stallreq_for_ex = 1'b1;
                    if (w_div_zero)       w_state_next = S_DZERO;
                    else if (w_fast_path) w_state_next = S_DONE;
                    else                  w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                stallreq_for_ex = 1'b1;
                if (annul)                   w_state_next = S_IDLE;
                else if (r_cnt == 5'd31)     w_state_next = S_DONE;
            end
            S_DZERO: begin
                stallreq_for_ex = 1'b1;
                w_state_next    = annul ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operand capture on accept, one iteration per BUSY cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rq      <= 64'd0;
            r_dvsr    <= 32'd0;
            r_cnt     <= 5'd0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
        end else if (w_accept) begin
            r_cnt     <= 5'd0;
            r_is_div  <= w_op_div;
            r_neg_res <= w_op_signed && (src1[31] ^ src2[31]);
            r_neg_rem <= w_op_signed && src1[31];
            if (w_op_div) begin
                r_rq   <= {32'd0, w_abs1};
                r_dvsr <= w_abs2;
            end else begin
                r_rq   <= {32'd0, w_abs2};
                r_dvsr <= w_abs1;
            end
        end else if (r_state == S_BUSY) begin
            r_rq  <= w_rq_next;
            r_cnt <= r_cnt + 5'd1;
        end
    end

    // ------------------------------------------------------------------
    // Registered HI/LO write port. Enables pulse for one cycle; write data
    // holds its last value otherwise.
    // ------------------------------------------------------------------
    logic        r_ready;
    logic        r_hi_we;
    logic        r_lo_we;
    logic [31:0] r_hi_wdata;
    logic [31:0] r_lo_wdata;

    // Launch the result (or MT write) into the output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready    <= 1'b0;
            r_hi_we    <= 1'b0;
            r_lo_we    <= 1'b0;
            r_hi_wdata <= 32'd0;
            r_lo_wdata <= 32'd0;
        end else begin
            r_ready <= 1'b0;
            r_hi_we <= 1'b0;
            r_lo_we <= 1'b0;
            if (w_accept && w_fast_path && !w_div_zero) begin
                r_ready    <= 1'b1;
                r_hi_we    <= 1'b1;
                r_lo_we    <= 1'b1;
                r_hi_wdata <= w_fast_prod[63:32];
                r_lo_wdata <= w_fast_prod[31:0];
            end else if (r_state == S_IDLE && !w_op_any) begin
                // MT writes only when no MDU op is requested alongside.
                if (mthi) begin
                    r_hi_we    <= 1'b1;
                    r_hi_wdata <= src1;
                end
                if (mtlo) begin
                    r_lo_we    <= 1'b1;
                    r_lo_wdata <= src1;
                end
            end else if (w_last_iter) begin
                r_ready    <= 1'b1;
                r_hi_we    <= 1'b1;
                r_lo_we    <= 1'b1;
                r_hi_wdata <= w_fin_hi;
                r_lo_wdata <= w_fin_lo;
            end else if (r_state == S_DZERO && !annul) begin
                r_ready    <= 1'b1;
                r_hi_we    <= 1'b1;
                r_lo_we    <= 1'b1;
                r_hi_wdata <= 32'd0;
                r_lo_wdata <= 32'd0;
            end
        end
    end

    // An annul arriving during DONE kills that cycle's write and ready.
    logic w_done_kill;
    assign w_done_kill = annul && (r_state == S_DONE);

    assign ready    = r_ready && !w_done_kill;
    assign hi_we    = r_hi_we && !w_done_kill;
    assign lo_we    = r_lo_we && !w_done_kill;
    assign hi_wdata = r_hi_wdata;
    assign lo_wdata = r_lo_wdata;

endmodule

`default_nettype wire
